// File: rtl/imem_responder.sv
// imem_responder
//   Instruction-bus responder between the prefetch unit and a single-port
//   synchronous instruction SRAM. Word fetch requests arrive on a valid/ready
//   port. Each request is checked for alignment, address range and privilege.
//   Good requests read the SRAM. Responses (data or read error) return in
//   request order through a one-stage read pipeline (s1) backed by a
//   two-entry response buffer that absorbs response back-pressure.
//
// Ports
//   clk_i        clock
//   clk_en_i     clock enable; all state holds and no handshake completes while low
//   resetb_i     asynchronous active-low reset
//   ireqvalid_i  request valid
//   ireqready_o  request ready (combinational: credit available and clock enabled)
//   ireqhpl_i    privilege level of the request (2'b00 = user)
//   ireqaddr_i   request byte address
//   irspvalid_o  response valid
//   irspready_i  response ready
//   irsprerr_o   response is a read error (0 when irspvalid_o is 0)
//   irspdata_o   response data (0 when irspvalid_o is 0 or on error)
//   mem_rd_o     SRAM read strobe
//   mem_addr_o   SRAM word address (always follows ireqaddr_i)
//   mem_rdata_i  SRAM read data, valid the cycle after mem_rd_o, then held

module imem_responder #(
    parameter int unsigned                 C_BUS_SZX     = 5,
    parameter int unsigned                 C_MEM_ADDR_SZ = 10,
    parameter logic [(2**C_BUS_SZX)-1:0]   C_MEM_BASE    = '0,
    parameter logic [(2**C_BUS_SZX)-1:0]   C_USER_BASE   = '0
) (
    input  logic                      clk_i,
    input  logic                      clk_en_i,
    input  logic                      resetb_i,

    input  logic                      ireqvalid_i,
    output logic                      ireqready_o,
    input  logic [1:0]                ireqhpl_i,
    input  logic [(2**C_BUS_SZX)-1:0] ireqaddr_i,

    output logic                      irspvalid_o,
    input  logic                      irspready_i,
    output logic                      irsprerr_o,
    output logic [(2**C_BUS_SZX)-1:0] irspdata_o,

    output logic                      mem_rd_o,
    output logic [C_MEM_ADDR_SZ-1:0]  mem_addr_o,
    input  logic [(2**C_BUS_SZX)-1:0] mem_rdata_i
);

    localparam int unsigned C_BUS_SZ   = 2**C_BUS_SZX;
    localparam int unsigned C_WORD_LSB = 2;
    localparam int unsigned C_RANGE_SH = C_MEM_ADDR_SZ + C_WORD_LSB;
    localparam int unsigned C_BUF_DEPTH = 2;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    logic                 acc;
    logic                 req_err;
    logic                 align_err;
    logic                 below_base;
    logic                 range_err;
    logic                 priv_err;
    logic                 credit_full;
    logic [C_BUS_SZ-1:0]  off;

    // ------------------------------------------------------------------
    // Read stage and response buffer state
    // ------------------------------------------------------------------
    logic                 s1_valid;
    logic                 s1_err;
    logic [C_BUS_SZ-1:0]  s1_data;

    logic [1:0]           buf_count;
    logic                 buf_wr_ptr;
    logic                 buf_rd_ptr;
    logic                 buf_err  [C_BUF_DEPTH];
    logic [C_BUS_SZ-1:0]  buf_data [C_BUF_DEPTH];
    logic                 buf_empty;

    logic                 rsp_err_c;
    logic [C_BUS_SZ-1:0]  rsp_data_c;
    logic                 bypass;
    logic                 pop;
    logic                 pop_buf;
    logic                 push;

    // Offset of the request from the start of the SRAM window (modulo bus width)
    assign off = ireqaddr_i - C_MEM_BASE;

    // Request error classification
    assign align_err  = |ireqaddr_i[C_WORD_LSB-1:0];
    assign below_base = ireqaddr_i < C_MEM_BASE;
    // Any offset bit above the SRAM word index means the word lies past the end
    assign range_err  = (off >> C_RANGE_SH) != '0;
    assign priv_err   = (ireqhpl_i == 2'b00) && (ireqaddr_i < C_USER_BASE);
    assign req_err    = align_err | below_base | range_err | priv_err;

    // Credit: s1 plus buffered entries may never exceed the buffer depth.
    // A pop in the same cycle does not return credit until the next cycle.
    assign credit_full = (buf_count == 2'd2) || ((buf_count == 2'd1) && s1_valid);
    assign ireqready_o = clk_en_i & ~credit_full;
    assign acc         = ireqvalid_i & ireqready_o;

    // SRAM access; error requests never strobe the memory
    assign mem_rd_o   = acc & ~req_err;
    assign mem_addr_o = off[C_MEM_ADDR_SZ+C_WORD_LSB-1:C_WORD_LSB];

    // ------------------------------------------------------------------
    // Response selection: buffer head first, otherwise bypass s1
    // ------------------------------------------------------------------
    assign buf_empty = (buf_count == 2'd0);
    assign s1_data   = s1_err ? '0 : mem_rdata_i;

    assign rsp_err_c  = buf_empty ? s1_err  : buf_err[buf_rd_ptr];
    assign rsp_data_c = buf_empty ? s1_data : buf_data[buf_rd_ptr];

    assign irspvalid_o = clk_en_i & (~buf_empty | s1_valid);
    assign irsprerr_o  = irspvalid_o & rsp_err_c;
    assign irspdata_o  = irspvalid_o ? rsp_data_c : '0;

    assign pop     = irspvalid_o & irspready_i;
    assign bypass  = buf_empty & s1_valid;
    assign pop_buf = pop & ~buf_empty;
    // s1 lives one enabled cycle: either it leaves via bypass or it is parked
    // in the buffer (SRAM data is captured now, before a later read can replace it)
    assign push    = clk_en_i & s1_valid & ~(bypass & pop);

    // Read stage: one entry per accepted request, latched with its error flag
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
        end else if (clk_en_i) begin
            s1_valid <= acc;
            s1_err   <= acc & req_err;
        end
    end

    // Two-entry response FIFO with occupancy counter
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            buf_count  <= 2'd0;
            buf_wr_ptr <= 1'b0;
            buf_rd_ptr <= 1'b0;
            for (int i = 0; i < C_BUF_DEPTH; i++) begin
                buf_err[i]  <= 1'b0;
                buf_data[i] <= '0;
            end
        end else begin
            if (push) begin
                buf_err[buf_wr_ptr]  <= s1_err;
                buf_data[buf_wr_ptr] <= s1_data;
                buf_wr_ptr           <= ~buf_wr_ptr;
            end
            if (pop_buf) begin
                buf_rd_ptr <= ~buf_rd_ptr;
            end
            case ({push, pop_buf})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

endmodule
